register_array_pq: RTL
======================

Name: register_array_pq

Overview:
- Parametrised successor to the fixed-depth register-array max queue.
- Adds explicit enqueue, dequeue and replace operations, per-slot valid tracking, occupancy flags, and selectable max-first or min-first ordering.
- A shift-register sorted array: every slot keeps order every cycle, so the head is always the top-priority entry one cycle after any operation.
- Sits in front of schedulers that need a single-cycle top-of-queue read.

Parameters:
- QUEUE_SIZE, 8, number of slots (>=2).
- DATA_WIDTH, 32, key width in bits.
- MAX_FIRST, 1, 1 = largest key at head; 0 = smallest key at head.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- enqueue  input  1  insert new_entry this cycle.
- dequeue  input  1  remove head this cycle.
- new_entry  input  DATA_WIDTH  key to insert.
- top_entry  output  DATA_WIDTH  head key (registered).
- top_valid  output  1  head slot holds a valid entry.
- count  output  $clog2(QUEUE_SIZE+1)  number of valid entries.
- empty  output  1  count==0.
- full  output  1  count==QUEUE_SIZE.

Behaviour:
- State: slot[0..QUEUE_SIZE-1] = {valid, data}. Valid slots are contiguous from slot 0 and sorted by priority.
- "Higher priority" means greater key if MAX_FIRST=1, smaller key if MAX_FIRST=0.
- Reset (rst=0, async): all slots invalid, data 0. Outputs: top_entry=0, top_valid=0, count=0, empty=1, full=0. Reset mid-operation discards all contents immediately.
- All outputs are registered. The effect of an operation is visible on the cycle after the clock edge that samples it (latency 1). Back-to-back operations are allowed every cycle.
- Insert position p = lowest index i where slot[i] is invalid, or new_entry has strictly higher priority than slot[i].data. Equal keys go after existing equals, so equal keys leave in FIFO order.
- Enqueue only (not full): slots p..N-2 shift down one place; slot[p] <= new_entry; count+1.
- Enqueue only when full: request dropped; state unchanged.
- Dequeue only (not empty): slots 1..N-1 shift up one place; last slot becomes invalid with data 0; count-1.
- Dequeue only when empty: ignored; state unchanged.
- Enqueue+dequeue when not empty (replace): the head is removed and new_entry is inserted in one cycle, with p computed over slots 1..N-1 as if already shifted up. count unchanged. Allowed when full.
- Enqueue+dequeue when empty: treated as enqueue only; count becomes 1.
- Vacated or invalid slots always hold data 0, so top_entry=0 whenever top_valid=0.
- Comparisons are unsigned, full DATA_WIDTH. No arithmetic beyond the count increment/decrement; count never wraps.

Optional Feature:
- Macro: REGISTER_ARRAY_PQ_ERR_EN.
- When defined, adds output ports overflow (1) and underflow (1), both sticky:
  - overflow sets on an enqueue-only request while full.
  - underflow sets on a dequeue-only request while empty.
  - Both clear only on reset. Reset value 0.
- When not defined: the ports do not exist, and dropped or ignored requests are silent. Queue behaviour is identical in both builds.

Test Plan (QUEUE_SIZE=4, DATA_WIDTH=8, MAX_FIRST=1 unless noted):
- Reset, then idle -> top_valid=0, top_entry=0, count=0, empty=1, full=0.
- Enqueue 20, 50, 10, 50 on consecutive cycles -> after each: top_entry 20, 50, 50, 50; count 1..4; full=1 after the fourth. Then dequeue x4 -> head sequence 50 (first), 50 (second), 20, 10; empty=1.
- Full queue {50,40,30,20}; enqueue 60 alone -> state unchanged, count=4. With REGISTER_ARRAY_PQ_ERR_EN, overflow=1.
- Full queue {50,40,30,20}; enqueue+dequeue with new 35 -> contents {40,35,30,20}, top_entry=40, count=4.
- Empty queue; dequeue alone -> no change, underflow=1 if enabled. Then enqueue+dequeue with new 7 -> top_entry=7, count=1.
- MAX_FIRST=0: enqueue 30, 10, 20, then dequeue x3 -> head 10, 20, 30. Assert rst=0 mid-stream -> outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/register_array_pq.sv
// rtl/register_array_pq.sv - shift-register sorted priority queue with enqueue, dequeue and replace
// Optional sticky overflow/underflow outputs: define REGISTER_ARRAY_PQ_ERR_EN.
module register_array_pq #(
    parameter int QUEUE_SIZE = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_FIRST = 1,
    localparam int COUNT_WIDTH = $clog2(QUEUE_SIZE + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enqueue,
    input  logic                   dequeue,
    input  logic [DATA_WIDTH-1:0]  new_entry,
    output logic [DATA_WIDTH-1:0]  top_entry,
    output logic                   top_valid,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   empty,
    output logic                   full
`ifdef REGISTER_ARRAY_PQ_ERR_EN
    ,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    logic                  valid_q [QUEUE_SIZE];
    logic [DATA_WIDTH-1:0] data_q  [QUEUE_SIZE];
    logic                  base_v  [QUEUE_SIZE];
    logic [DATA_WIDTH-1:0] base_d  [QUEUE_SIZE];
    logic                  next_v  [QUEUE_SIZE];
    logic [DATA_WIDTH-1:0] next_d  [QUEUE_SIZE];
    logic                  ins     [QUEUE_SIZE];
    logic [COUNT_WIDTH-1:0] count_q, count_n;
    logic                  empty_q, full_q;
    logic                  do_shift, do_insert;

    // True when key a must sit ahead of key b; strict so equal keys keep arrival order.
    function automatic logic beats(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        if (MAX_FIRST != 0) begin
            return a > b;
        end else begin
            return a < b;
        end
    endfunction

    // Next-state: optional shift-up for a dequeue, then insertion into the (shifted) array.
    always_comb begin
        do_shift  = dequeue && !empty_q;
        do_insert = enqueue && (!full_q || do_shift);

        for (int i = 0; i < QUEUE_SIZE - 1; i++) begin
            base_v[i] = do_shift ? valid_q[i+1] : valid_q[i];
            base_d[i] = do_shift ? data_q[i+1]  : data_q[i];
        end
        base_v[QUEUE_SIZE-1] = do_shift ? 1'b0 : valid_q[QUEUE_SIZE-1];
        base_d[QUEUE_SIZE-1] = do_shift ? '0   : data_q[QUEUE_SIZE-1];

        // Sorted, contiguous contents make ins monotone: false up to p, true from p on.
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            ins[i]    = !base_v[i] || beats(new_entry, base_d[i]);
            next_v[i] = base_v[i];
            next_d[i] = base_d[i];
        end

        if (do_insert) begin
            if (ins[0]) begin
                next_v[0] = 1'b1;
                next_d[0] = new_entry;
            end
            for (int i = 1; i < QUEUE_SIZE; i++) begin
                if (ins[i]) begin
                    next_v[i] = ins[i-1] ? base_v[i-1] : 1'b1;
                    next_d[i] = ins[i-1] ? base_d[i-1] : new_entry;
                end
            end
        end

        count_n = count_q;
        if (do_insert && !do_shift) begin
            count_n = count_q + COUNT_WIDTH'(1);
        end else if (do_shift && !do_insert) begin
            count_n = count_q - COUNT_WIDTH'(1);
        end
    end

    // Slot array and occupancy registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                valid_q[i] <= next_v[i];
                data_q[i]  <= next_d[i];
            end
            count_q <= count_n;
            empty_q <= (count_n == '0);
            full_q  <= (count_n == COUNT_WIDTH'(QUEUE_SIZE));
        end
    end

    assign top_entry = data_q[0];
    assign top_valid = valid_q[0];
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;

`ifdef REGISTER_ARRAY_PQ_ERR_EN
    logic overflow_q, underflow_q;

    // Sticky flags for dropped enqueues and ignored dequeues; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (enqueue && !dequeue && full_q) begin
                overflow_q <= 1'b1;
            end
            if (dequeue && !enqueue && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
